// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the fetch PC unit: state encoding, instruction width, BTB geometry.
// RAM_ADR_W falls back to 32 when the surrounding build does not define it.
`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif

package fetch_pc_unit_pkg;

   localparam int unsigned FETCH_INST_W = 32;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_WAIT,
      FS_DRAIN
   } fetch_state_t;

   function automatic int unsigned btb_idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Tag covers everything above the index and the two byte-offset bits.
   function automatic int unsigned btb_tag_w(input int unsigned addr_w, input int unsigned depth);
      return addr_w - 2 - $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Single-outstanding instruction-cache port between the fetch unit (master) and the icache (slave).
interface fetch_pc_unit_if
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = `RAM_ADR_W,
   parameter int unsigned INST_W = FETCH_INST_W
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_pc;
   logic              req_ready;
   logic              rsp_valid;
   logic [INST_W-1:0] rsp_data;

   modport master (
      output req_valid, req_pc,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_pc,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer for the fetch unit; lookup is combinational on the
// current fetch PC, updates land at the clock edge so a same-cycle lookup sees old contents.
module fetch_btb
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              hit,
   output logic [ADDR_W-1:0] target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_tgt,
   input  logic              upd_taken
);
   localparam int unsigned IDX_W = btb_idx_w(DEPTH);
   localparam int unsigned TAG_W = btb_tag_w(ADDR_W, DEPTH);

   logic [DEPTH-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem [DEPTH];
   logic [ADDR_W-3:0] tgt_mem [DEPTH];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             unused_low_bits;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
   assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_tgt[1:0]};

   assign hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
   assign target = {tgt_mem[lk_idx], 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (upd_en) begin
         valid[up_idx] <= upd_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (upd_en && upd_taken) begin
         tag_mem[up_idx] <= up_tag;
         tgt_mem[up_idx] <= upd_tgt[ADDR_W-1:2];
      end
   end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues one icache request at a time, holds one instruction for decode,
// redirects on flush/prediction and squashes stale responses. Optional BTB via FETCH_BTB_EN.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W    = `RAM_ADR_W,
   parameter int unsigned       INST_W    = FETCH_INST_W,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       BTB_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush_en_i,
   input  logic [ADDR_W-1:0]    flush_pc_i,
   input  logic                 pred_en_i,
   input  logic [ADDR_W-1:0]    pred_pc_i,
   fetch_pc_unit_if.master      ic,
   output logic                 inst_valid_o,
   output logic [INST_W-1:0]    inst_o,
   output logic [ADDR_W-1:0]    inst_pc_o,
   output logic                 pred_taken_o,
   input  logic                 dec_ready_i,
   input  logic                 btb_upd_en_i,
   input  logic [ADDR_W-1:0]    btb_upd_pc_i,
   input  logic [ADDR_W-1:0]    btb_upd_tgt_i,
   input  logic                 btb_upd_taken_i
);
   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc_q, pc_next, next_seq, redir_pc;
   logic              redir, load;
   logic              btb_hit;
   logic [ADDR_W-1:0] btb_tgt;
   logic              unused_pc_bits;

   assign redir          = flush_en_i | pred_en_i;
   assign redir_pc       = {(flush_en_i ? flush_pc_i[ADDR_W-1:2] : pred_pc_i[ADDR_W-1:2]), 2'b00};
   assign unused_pc_bits = ^{flush_pc_i[1:0], pred_pc_i[1:0]};

`ifdef FETCH_BTB_EN
   fetch_btb #(
      .ADDR_W (ADDR_W),
      .DEPTH  (BTB_DEPTH)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .lookup_pc (pc_q),
      .hit       (btb_hit),
      .target    (btb_tgt),
      .upd_en    (btb_upd_en_i),
      .upd_pc    (btb_upd_pc_i),
      .upd_tgt   (btb_upd_tgt_i),
      .upd_taken (btb_upd_taken_i)
   );
`else
   logic unused_btb_ports;
   assign btb_hit          = 1'b0;
   assign btb_tgt          = '0;
   assign unused_btb_ports = ^{btb_upd_en_i, btb_upd_pc_i, btb_upd_tgt_i, btb_upd_taken_i};
`endif

   assign next_seq     = btb_hit ? btb_tgt : pc_q + ADDR_W'(4);
   assign ic.req_valid = (state == FS_REQ);
   assign ic.req_pc    = pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FS_IDLE;
      else      state <= state_next;
   end

   // A redirect in WAIT drops the response: if it arrives the same cycle nothing is left to drain.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      unique case (state)
         FS_IDLE:  if (!redir && en && (!inst_valid_o || dec_ready_i)) state_next = FS_REQ;
         FS_REQ:   if (ic.req_ready) state_next = redir ? FS_DRAIN : FS_WAIT;
         FS_WAIT: begin
            if (ic.rsp_valid) begin
               state_next = FS_IDLE;
               load       = !redir;
            end else if (redir) begin
               state_next = FS_DRAIN;
            end
         end
         FS_DRAIN: if (ic.rsp_valid) state_next = FS_IDLE;
         default:  state_next = FS_IDLE;
      endcase
   end

   always_comb begin
      pc_next = pc_q;
      if (redir)     pc_next = redir_pc;
      else if (load) pc_next = next_seq;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_VEC;
         inst_valid_o <= 1'b0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         pred_taken_o <= 1'b0;
      end else begin
         pc_q <= pc_next;
         if (load) begin
            inst_valid_o <= 1'b1;
            inst_o       <= ic.rsp_data;
            inst_pc_o    <= pc_q;
            pred_taken_o <= btb_hit;
         end else if (redir || (dec_ready_i && inst_valid_o)) begin
            inst_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: an icache responder, a PC/slot model and per-scenario tasks.
// Define FETCH_BTB_EN on both RTL and bench to exercise the BTB scenario.
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned IW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          flush_en = 1'b0, pred_en = 1'b0;
   logic [AW-1:0] flush_pc = '0, pred_pc = '0;
   logic          inst_valid, pred_taken;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          dec_ready = 1'b0;
   logic          btb_upd_en = 1'b0, btb_upd_taken = 1'b0;
   logic [AW-1:0] btb_upd_pc = '0, btb_upd_tgt = '0;

   fetch_pc_unit_if #(.ADDR_W(AW), .INST_W(IW)) ic ();

   fetch_pc_unit #(
      .ADDR_W    (AW),
      .INST_W    (IW),
      .RESET_VEC (32'h0),
      .BTB_DEPTH (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .flush_en_i      (flush_en),
      .flush_pc_i      (flush_pc),
      .pred_en_i       (pred_en),
      .pred_pc_i       (pred_pc),
      .ic              (ic),
      .inst_valid_o    (inst_valid),
      .inst_o          (inst),
      .inst_pc_o       (inst_pc),
      .pred_taken_o    (pred_taken),
      .dec_ready_i     (dec_ready),
      .btb_upd_en_i    (btb_upd_en),
      .btb_upd_pc_i    (btb_upd_pc),
      .btb_upd_tgt_i   (btb_upd_tgt),
      .btb_upd_taken_i (btb_upd_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] data;
      logic          pred;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   bit            last_hs;
   logic [AW-1:0] last_hs_pc;
   logic [AW-1:0] m_pc;
   bit            m_pend, m_squash;
   int            rsp_cnt = 0;
   int            rsp_lat = 1;
   logic [AW-1:0] rsp_pc;
   bit            ovr = 1'b0;
   logic [IW-1:0] ovr_data = '0;

`ifdef FETCH_BTB_EN
   bit            mb_v   [16];
   logic [25:0]   mb_tag [16];
   logic [AW-1:0] mb_tgt [16];
`endif

   function automatic logic [IW-1:0] mem(input logic [AW-1:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9bdf;
   endfunction

   // One clock: check/advance the model on pre-edge values, then drive the icache response.
   task automatic tick();
      logic          hs, rdr, cons, rsp, ld, hit;
      logic [AW-1:0] tgt, nxt;
      exp_t          e;
      hs   = ic.req_valid && ic.req_ready;
      rdr  = flush_en || pred_en;
      tgt  = flush_en ? flush_pc : pred_pc;
      tgt[1:0] = 2'b00;
      cons = inst_valid && dec_ready;
      rsp  = ic.rsp_valid;
      if (hs) begin
         total++;
         if (ic.req_pc !== m_pc) begin
            bad++;
            $display("FAIL req_pc: got %h want %h", ic.req_pc, m_pc);
         end
      end
      last_hs    = hs;
      last_hs_pc = ic.req_pc;
      if (cons) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL slot_unexpected: got inst %h pc %h want empty slot", inst, inst_pc);
         end else begin
            e = sb.pop_front();
            if ({inst, inst_pc, pred_taken} !== {e.data, e.pc, e.pred}) begin
               bad++;
               $display("FAIL slot_data: got %h/%h/%b want %h/%h/%b",
                        inst, inst_pc, pred_taken, e.data, e.pc, e.pred);
            end
         end
      end
      ld  = rsp && m_pend && !m_squash && !rdr;
      hit = 1'b0;
      nxt = m_pc + 32'd4;
`ifdef FETCH_BTB_EN
      if (mb_v[m_pc[5:2]] && mb_tag[m_pc[5:2]] == m_pc[31:6]) begin
         hit = 1'b1;
         nxt = mb_tgt[m_pc[5:2]];
      end
      if (btb_upd_en) begin
         mb_v[btb_upd_pc[5:2]] = btb_upd_taken;
         if (btb_upd_taken) begin
            mb_tag[btb_upd_pc[5:2]] = btb_upd_pc[31:6];
            mb_tgt[btb_upd_pc[5:2]] = {btb_upd_tgt[31:2], 2'b00};
         end
      end
`endif
      if (rdr) begin
         m_pc = tgt;
         if (!cons && sb.size() > 0) void'(sb.pop_front());
      end else if (ld) begin
         sb.push_back('{pc: m_pc, data: ic.rsp_data, pred: hit});
         m_pc = nxt;
      end
      if (rsp) m_pend = 1'b0;
      if (hs) begin
         m_pend   = 1'b1;
         m_squash = rdr;
      end else if (m_pend) begin
         m_squash = m_squash | rdr;
      end
      @(posedge clk);
      #1;
      cyc++;
      ic.rsp_valid = 1'b0;
      if (hs) begin
         rsp_cnt = rsp_lat;
         rsp_pc  = last_hs_pc;
      end
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            ic.rsp_valid = 1'b1;
            ic.rsp_data  = ovr ? ovr_data : mem(rsp_pc);
         end
      end
      total++;
      if (inst_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL slot_valid: got %b want %b", inst_valid, sb.size() != 0);
      end
   endtask

   task automatic run_hs(input int limit, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         tick();
         got = last_hs;
      end
   endtask

   task automatic drain_idle();
      bit done = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         done = !ic.req_valid && !m_pend && rsp_cnt == 0 && !ic.rsp_valid;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL drain_timeout: got busy want idle");
      end
   endtask

   task automatic redirect_once(input logic f, input logic [AW-1:0] fpc,
                                input logic p, input logic [AW-1:0] ppc);
      flush_en = f; flush_pc = fpc; pred_en = p; pred_pc = ppc;
      tick();
      flush_en = 1'b0; pred_en = 1'b0;
   endtask

   task automatic test_reset();
      ic.req_ready = 1'b1;
      ic.rsp_valid = 1'b0;
      ic.rsp_data  = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      total += 6;
      if (ic.req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", ic.req_valid); end
      if (ic.req_pc !== 32'h0)   begin bad++; $display("FAIL rst_req_pc: got %h want 0", ic.req_pc); end
      if (inst_valid !== 1'b0)   begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
      if (inst !== 32'h0)        begin bad++; $display("FAIL rst_inst: got %h want 0", inst); end
      if (inst_pc !== 32'h0)     begin bad++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
      if (pred_taken !== 1'b0)   begin bad++; $display("FAIL rst_pred: got %b want 0", pred_taken); end
      m_pc = 32'h0; m_pend = 1'b0; m_squash = 1'b0; sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_sequential();
      int            n = 0;
      int            hc [3];
      logic [AW-1:0] hp [3];
      logic [AW-1:0] want;
      en = 1'b1; dec_ready = 1'b1; rsp_lat = 1;
      for (int i = 0; i < 40 && n < 3; i++) begin
         tick();
         if (last_hs) begin
            hc[n] = cyc;
            hp[n] = last_hs_pc;
            n++;
         end
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL seq_count: got %0d want 3", n);
      end else begin
         for (int k = 0; k < 3; k++) begin
            want = 32'(k * 4);
            total++;
            if (hp[k] !== want) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", k, hp[k], want); end
         end
         for (int k = 1; k < 3; k++) begin
            total++;
            if (hc[k] - hc[k-1] != 3) begin
               bad++;
               $display("FAIL seq_spacing%0d: got %0d want 3", k, hc[k] - hc[k-1]);
            end
         end
      end
   endtask

   task automatic test_dec_stall();
      bit            got = 1'b0;
      logic [IW-1:0] held;
      dec_ready = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = inst_valid;
      end
      total++;
      if (!got) begin bad++; $display("FAIL stall_load: got no instruction want one"); end
      held = inst;
      for (int i = 0; i < 10; i++) begin
         tick();
         total += 2;
         if (ic.req_valid !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", ic.req_valid); end
         if (inst !== held) begin bad++; $display("FAIL stall_hold: got %h want %h", inst, held); end
      end
      dec_ready = 1'b1;
      run_hs(10, got);
      total++;
      if (!got) begin bad++; $display("FAIL stall_resume: got no request want one"); end
   endtask

   task automatic test_flush_wait();
      bit got;
      drain_idle();
      rsp_lat = 2;
      redirect_once(1'b1, 32'h10, 1'b0, '0);
      en = 1'b1;
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h10) begin bad++; $display("FAIL fw_req: got %b/%h want 1/00000010", got, last_hs_pc); end
      ovr = 1'b1; ovr_data = 32'hDEADBEEF;
      redirect_once(1'b1, 32'h100, 1'b0, '0);
      tick();
      total++;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL fw_drop: got %b want 0", inst_valid); end
      ovr = 1'b0;
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h100) begin bad++; $display("FAIL fw_next: got %b/%h want 1/00000100", got, last_hs_pc); end
      // Response and redirect in the same WAIT cycle.
      drain_idle();
      rsp_lat = 1;
      redirect_once(1'b1, 32'h20, 1'b0, '0);
      en = 1'b1;
      run_hs(10, got);
      redirect_once(1'b0, '0, 1'b1, 32'h302);
      total++;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL fw_same_drop: got %b want 0", inst_valid); end
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h300) begin bad++; $display("FAIL fw_same_next: got %b/%h want 1/00000300", got, last_hs_pc); end
   endtask

   task automatic test_priority();
      bit got;
      drain_idle();
      redirect_once(1'b1, 32'h200, 1'b1, 32'h300);
      en = 1'b1;
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h200) begin bad++; $display("FAIL prio: got %b/%h want 1/00000200", got, last_hs_pc); end
   endtask

   task automatic test_wrap();
      bit got;
      drain_idle();
      redirect_once(1'b1, 32'hFFFF_FFFF, 1'b0, '0);
      en = 1'b1;
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", got, last_hs_pc); end
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h0) begin bad++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", got, last_hs_pc); end
   endtask

`ifdef FETCH_BTB_EN
   task automatic test_btb();
      bit got;
      bit seen;
      drain_idle();
      btb_upd_en = 1'b1; btb_upd_pc = 32'h40; btb_upd_tgt = 32'h80; btb_upd_taken = 1'b1;
      tick();
      btb_upd_en = 1'b0;
      redirect_once(1'b1, 32'h40, 1'b0, '0);
      en = 1'b1;
      run_hs(10, got);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = inst_valid;
      end
      total++;
      if (!seen || pred_taken !== 1'b1) begin bad++; $display("FAIL btb_pred: got %b/%b want 1/1", seen, pred_taken); end
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h80) begin bad++; $display("FAIL btb_tgt: got %b/%h want 1/00000080", got, last_hs_pc); end
      drain_idle();
      btb_upd_en = 1'b1; btb_upd_pc = 32'h40; btb_upd_taken = 1'b0;
      tick();
      btb_upd_en = 1'b0;
      redirect_once(1'b1, 32'h40, 1'b0, '0);
      en = 1'b1;
      run_hs(10, got);
      run_hs(10, got);
      total++;
      if (!got || last_hs_pc !== 32'h44) begin bad++; $display("FAIL btb_inval: got %b/%h want 1/00000044", got, last_hs_pc); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_dec_stall();
      test_flush_wait();
      test_priority();
      test_wrap();
`ifdef FETCH_BTB_EN
      test_btb();
`endif
      drain_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
